// File: rtl/decode_stage.sv
// Purpose : instruction decode stage; buffers fetched words in a small FIFO and
//           splits the head word into opcode/operand fields in an output register.
// Latency : a word pushed into an empty stage appears on the outputs one edge after the push.
// Backpressure: o_instr_accept drops when the FIFO is full; i_stall holds the
//           output register stable while the FIFO keeps filling.
//
// Ports:
//   i_clk, i_rst (sync, active-high), i_flush, i_stall
//   i_instr / i_instr_valid / o_instr_accept : fetch side handshake
//   o_opcode, o_operand1, o_operand2, o_ready : decoded instruction to execute
//   o_illegal, o_illegal_count                : illegal-opcode trap status
//
// Build option: define DECODE_ILLEGAL_TRAP_EN to replace illegal instructions with
// an all-zero instruction flagged by o_illegal and counted in o_illegal_count.
// Without it, words pass unmodified and both trap outputs are tied to zero.
module decode_stage #(
  parameter int INSTR_WIDTH = 16,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_stall,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic                   i_instr_valid,
  output logic                   o_instr_accept,
  output logic [3:0]             o_opcode,
  output logic [5:0]             o_operand1,
  output logic [5:0]             o_operand2,
  output logic                   o_ready,
  output logic                   o_illegal,
  output logic [7:0]             o_illegal_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [INSTR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;

  logic                   push;
  logic                   pop;
  logic                   consume;
  logic [INSTR_WIDTH-1:0] head;

  logic [3:0]             ld_opcode;
  logic [5:0]             ld_operand1;
  logic [5:0]             ld_operand2;
  logic                   ld_illegal;

  // Accept is based on pre-edge occupancy only: a full FIFO refuses even if the
  // output register drains this cycle.
  assign o_instr_accept = (count < DEPTH_C) && !i_rst;
  assign push           = i_instr_valid && o_instr_accept && !i_flush;
  // Head moves into the output register whenever that register is empty or
  // is being consumed this edge.
  assign pop            = (count != '0) && (!o_ready || !i_stall) && !i_flush;
  assign consume        = o_ready && !i_stall;
  assign head           = mem[rd_ptr];

  // Storage needs no reset: occupancy is tracked by count/pointers.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_instr;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic head_legal;

  always_comb begin
    head_legal = 1'b0;
    case (head[15:12])
      4'h0, 4'hB, 4'hD, 4'hF: head_legal = 1'b1;
      default:                head_legal = 1'b0;
    endcase
  end
`endif

  // Fields that get loaded on a pop; a trapped instruction becomes an all-zero NOP.
  always_comb begin
    ld_opcode   = head[15:12];
    ld_operand1 = head[11:6];
    ld_operand2 = head[5:0];
    ld_illegal  = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (!head_legal) begin
      ld_opcode   = 4'h0;
      ld_operand1 = 6'h00;
      ld_operand2 = 6'h00;
      ld_illegal  = 1'b1;
    end
`endif
  end

  // Output register: reset beats flush, flush beats load and stall. On a
  // consume with nothing to load, only o_ready drops; fields keep last value.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      o_ready    <= 1'b0;
      o_opcode   <= 4'h0;
      o_operand1 <= 6'h00;
      o_operand2 <= 6'h00;
    end else if (pop) begin
      o_ready    <= 1'b1;
      o_opcode   <= ld_opcode;
      o_operand1 <= ld_operand1;
      o_operand2 <= ld_operand2;
    end else if (consume) begin
      o_ready    <= 1'b0;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Flush clears the flag but leaves the running count alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_illegal       <= 1'b0;
      o_illegal_count <= 8'h00;
    end else if (i_flush) begin
      o_illegal       <= 1'b0;
    end else if (pop) begin
      o_illegal       <= ld_illegal;
      if (ld_illegal && (o_illegal_count != 8'hFF)) begin
        o_illegal_count <= o_illegal_count + 8'd1;
      end
    end
  end
`else
  logic unused_ld_illegal;
  assign unused_ld_illegal = ld_illegal;
  assign o_illegal         = 1'b0;
  assign o_illegal_count   = 8'h00;
`endif

endmodule
